// File: rtl/med_pkg.sv
// Shared defaults and helpers for the median-filter datapath.
// No logic; constants and pure functions only.
// Used by the window generator and by the sort/median stages.
package med_pkg;

  localparam int DW_DEF    = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  // Counter width able to index 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Picks which row/column of the raw 3x3 block feeds tap k (0 = oldest)
  // given the position pos of the newest pixel: in-range taps keep their
  // own slot, out-of-range taps fall back to the nearest in-range slot.
  function automatic logic [1:0] tap_sel(input int k, input int pos);
    return (pos >= 2 - k) ? 2'(k) : 2'(2 - pos);
  endfunction

endpackage

// File: rtl/med_window_3x3_if.sv
// Pixel stream in / 3x3 window out bundle for med_window_3x3.
// Master drives the pixel stream, slave (the window generator) drives the window.
// No backpressure: in_de is a plain valid, out_de follows it one clock later.
interface med_window_3x3_if
  import med_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) ();

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  logic          in_vs;
  logic          in_de;
  logic [DW-1:0] in_data;
  logic          out_de;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;

  modport master (
    output in_vs, in_de, in_data,
    input  out_de, out_col, out_row,
    input  m11, m12, m13, m21, m22, m23, m31, m32, m33
  );

  modport slave (
    input  in_vs, in_de, in_data,
    output out_de, out_col, out_row,
    output m11, m12, m13, m21, m22, m23, m31, m32, m33
  );

endinterface

// File: rtl/med_line_buf.sv
// One video line of storage, single port, addressed by column.
// Read is combinational; the write lands on the clock edge (read-before-write).
// No backpressure: writes whenever we_i is high. Contents are not reset.
module med_line_buf
  import med_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Store the incoming pixel after the old value has been read out.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/med_window_3x3.sv
// Raster grey stream -> registered 3x3 neighbourhood, one window per pixel.
// Latency 1 clk; out_de is in_de delayed, outputs hold while out_de is low.
// No backpressure. MED_BORDER_REPLICATE_EN selects edge replication over zeros.
module med_window_3x3
  import med_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  med_window_3x3_if.slave bus
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [DW-1:0] b1_rd, b2_rd;
  logic [DW-1:0] sh_q  [3][2];
  logic [DW-1:0] raw   [3][3];
  logic [DW-1:0] win_d [3][3];
  logic [DW-1:0] win_q [3][3];
  logic          out_de_q;
  logic [CW-1:0] col_o_q;
  logic [RW-1:0] row_o_q;
  int            rc, cc;

  // Position of the current pixel (frame start forces 0,0) and next position.
  always_comb begin
    col_cur = bus.in_vs ? '0 : col_q;
    row_cur = bus.in_vs ? '0 : row_q;
    col_d   = col_cur;
    row_d   = row_cur;
    if (bus.in_de) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // buf1 holds the previous line, buf2 the line before that.
  med_line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_buf1 (
    .clk(clk), .we_i(bus.in_de), .addr_i(col_cur), .wdata_i(bus.in_data), .rdata_o(b1_rd)
  );
  med_line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_buf2 (
    .clk(clk), .we_i(bus.in_de), .addr_i(col_cur), .wdata_i(b1_rd), .rdata_o(b2_rd)
  );

  // Unmasked 3x3 block as it will look after this pixel shifts in.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      raw[i][0] = sh_q[i][0];
      raw[i][1] = sh_q[i][1];
    end
    raw[0][2] = b2_rd;
    raw[1][2] = b1_rd;
    raw[2][2] = bus.in_data;
  end

  // Border handling: taps above row 0 or left of column 0 are zeroed or replicated.
  always_comb begin
    rc = int'(row_cur);
    cc = int'(col_cur);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
`ifdef MED_BORDER_REPLICATE_EN
        win_d[i][j] = raw[tap_sel(i, rc)][tap_sel(j, cc)];
`else
        win_d[i][j] = (rc >= 2 - i && cc >= 2 - j) ? raw[i][j] : '0;
`endif
      end
    end
  end

  // Column shift registers and registered window; both advance only on in_de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= '{default: '0};
      win_q    <= '{default: '0};
      out_de_q <= 1'b0;
      col_o_q  <= '0;
      row_o_q  <= '0;
    end else begin
      out_de_q <= bus.in_de;
      if (bus.in_de) begin
        for (int i = 0; i < 3; i++) begin
          sh_q[i][0] <= raw[i][1];
          sh_q[i][1] <= raw[i][2];
        end
        win_q   <= win_d;
        col_o_q <= col_cur;
        row_o_q <= row_cur;
      end
    end
  end

  assign bus.out_de  = out_de_q;
  assign bus.out_col = col_o_q;
  assign bus.out_row = row_o_q;
  assign bus.m11 = win_q[0][0];
  assign bus.m12 = win_q[0][1];
  assign bus.m13 = win_q[0][2];
  assign bus.m21 = win_q[1][0];
  assign bus.m22 = win_q[1][1];
  assign bus.m23 = win_q[1][2];
  assign bus.m31 = win_q[2][0];
  assign bus.m32 = win_q[2][1];
  assign bus.m33 = win_q[2][2];

endmodule
